dvi_blue_channel_tx: RTL and testbench

//  Transmit side of the DVI blue channel, clocked by the pixel clock.
//  - Generates VGA-style raster timing (hsync, vsync, de).
//  - Supplies pixel coordinates to a pixel source.
//  - TMDS-encodes blue data during active video, with running-disparity DC balance.
//  - Emits {C1,C0}={vsync,hsync} control tokens during blanking.
//  - Output is a parallel 10-bit word for an external serializer; this block is the

---
 rtl/dvi_blue_channel_tx.sv | 191 +++++++++++++++++++
 tb/tb_dvi_blue_channel_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dvi_blue_channel_tx.sv
// DVI blue-channel transmitter: raster timing, 3-stage TMDS encoder, control tokens.
// Optional macro TEST_PATTERN_EN replaces pix_b with an x^y test pattern.
module dvi_blue_channel_tx #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_b,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_active,
    output logic [9:0] tmds_word,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    // Transition-minimising stage; bit 8 records XOR (1) vs XNOR (0).
    function automatic logic [8:0] tmds_min(input logic [7:0] d);
        logic [3:0] n1;
        logic       xnor_sel;
        logic [8:0] q;
        n1       = ones8(d);
        xnor_sel = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = xnor_sel ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~xnor_sel;
        return q;
    endfunction

    logic [9:0] h_cnt, v_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign pix_x      = h_cnt;
    assign pix_y      = v_cnt;
    assign pix_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    logic       hs_on, vs_on;
    logic [7:0] src;
    assign hs_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef TEST_PATTERN_EN
    logic unused_pix_b;
    assign unused_pix_b = ^pix_b;
    assign src = pix_x[7:0] ^ pix_y[7:0];
`else
    assign src = pix_b;
`endif

    // S1: sync levels are stored as line levels so S3 can index tokens directly.
    logic       de1, hs1, vs1, fs1;
    logic [7:0] d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            de1 <= 1'b0;
            hs1 <= ~HS_POL;
            vs1 <= ~VS_POL;
            fs1 <= 1'b0;
            d1  <= '0;
        end else begin
            de1 <= pix_active;
            hs1 <= hs_on ? HS_POL : ~HS_POL;
            vs1 <= vs_on ? VS_POL : ~VS_POL;
            fs1 <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            d1  <= src;
        end
    end

    // S2
    logic       de2, hs2, vs2, fs2;
    logic [8:0] qm, qm2;
    logic [3:0] n1q, n0q;
    assign qm = tmds_min(d1);

    always_ff @(posedge clk) begin
        if (rst) begin
            de2 <= 1'b0;
            hs2 <= ~HS_POL;
            vs2 <= ~VS_POL;
            fs2 <= 1'b0;
            qm2 <= '0;
            n1q <= '0;
            n0q <= '0;
        end else begin
            de2 <= de1;
            hs2 <= hs1;
            vs2 <= vs1;
            fs2 <= fs1;
            qm2 <= qm;
            n1q <= ones8(qm[7:0]);
            n0q <= 4'd8 - ones8(qm[7:0]);
        end
    end

    // S3: DC balance; cnt is the running (ones - zeros) of words sent this line.
    logic signed [4:0] cnt;
    logic signed [5:0] cnt_ext, cnt_nx, n1s, n0s;
    logic        [9:0] word_nx;

    always_comb begin
        cnt_ext = {cnt[4], cnt};
        n1s     = $signed({2'b00, n1q});
        n0s     = $signed({2'b00, n0q});
        word_nx = '0;
        cnt_nx  = cnt_ext;
        if (cnt == 5'sd0 || n1q == n0q) begin
            word_nx = {~qm2[8], qm2[8], qm2[8] ? qm2[7:0] : ~qm2[7:0]};
            cnt_nx  = cnt_ext + (qm2[8] ? (n1s - n0s) : (n0s - n1s));
        end else if ((!cnt[4] && n1q > n0q) || (cnt[4] && n0q > n1q)) begin
            word_nx = {1'b1, qm2[8], ~qm2[7:0]};
            cnt_nx  = cnt_ext + (qm2[8] ? 6'sd2 : 6'sd0) + n0s - n1s;
        end else begin
            word_nx = {1'b0, qm2[8], qm2[7:0]};
            cnt_nx  = cnt_ext - (qm2[8] ? 6'sd0 : 6'sd2) + n1s - n0s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmds_word   <= ctrl_token({~VS_POL, ~HS_POL});
            de_o        <= 1'b0;
            hsync_o     <= ~HS_POL;
            vsync_o     <= ~VS_POL;
            frame_start <= 1'b0;
            cnt         <= '0;
        end else begin
            de_o        <= de2;
            hsync_o     <= hs2;
            vsync_o     <= vs2;
            frame_start <= fs2;
            if (de2) begin
                tmds_word <= word_nx;
                cnt       <= cnt_nx[4:0];
            end else begin
                tmds_word <= ctrl_token({vs2, hs2});
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dvi_blue_channel_tx.sv
// Bench for dvi_blue_channel_tx: reduced raster, random pixels, TMDS decoder and disparity model.
module tb_dvi_blue_channel_tx;

    localparam int HA = 40, HF = 4, HS = 8, HB = 8;
    localparam int VA = 20, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_b;
    logic [9:0] pix_x, pix_y, tmds_word;
    logic       pix_active, de_o, hsync_o, vsync_o, frame_start;

    dvi_blue_channel_tx #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pix_b(pix_b),
        .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .tmds_word(tmds_word), .de_o(de_o), .hsync_o(hsync_o),
        .vsync_o(vsync_o), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         disp = 0;
    logic [7:0] hist [0:8191];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Receiver-side TMDS decode.
    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    task automatic check_reset();
        chk("rst_word", 32'(tmds_word), 32'(10'b1010101011));
        chk("rst_de", 32'(de_o), 32'd0);
        chk("rst_hs", 32'(hsync_o), 32'd1);
        chk("rst_vs", 32'(vsync_o), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_x", 32'(pix_x), 32'd0);
        chk("rst_y", 32'(pix_y), 32'd0);
        chk("rst_act", 32'(pix_active), 32'd1);
    endtask

    // n = cycles since reset release; outputs lag raster position by 3.
    task automatic check_cycle(input int n);
        int   hh, vv, p, ph, pv;
        logic de_e, hs_e, vs_e, fs_e;
        hh = n % HT;
        vv = (n / HT) % VT;
        chk("pix_x", 32'(pix_x), 32'(hh));
        chk("pix_y", 32'(pix_y), 32'(vv));
        chk("pix_active", 32'(pix_active), 32'((hh < HA) && (vv < VA)));
        p = n - 3;
        if (p < 0) begin
            de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0;
            ph = 0; pv = 0;
        end else begin
            ph   = p % HT;
            pv   = (p / HT) % VT;
            de_e = (ph < HA) && (pv < VA);
            hs_e = !(ph >= HA + HF && ph < HA + HF + HS);
            vs_e = !(pv >= VA + VF && pv < VA + VF + VS);
            fs_e = (ph == 0) && (pv == 0);
        end
        chk("de_o", 32'(de_o), 32'(de_e));
        chk("hsync_o", 32'(hsync_o), 32'(hs_e));
        chk("vsync_o", 32'(vsync_o), 32'(vs_e));
        chk("frame_start", 32'(frame_start), 32'(fs_e));
        if (!de_e) begin
            chk("ctrl_token", 32'(tmds_word), 32'(token({vs_e, hs_e})));
            disp = 0;
        end else begin
            if (disp == 0) chk("bal_zero_sel", 32'(tmds_word[9] ^ tmds_word[8]), 32'd1);
            chk("decode", 32'(decode(tmds_word)), 32'(hist[p]));
            disp += 2 * $countones(tmds_word) - 10;
            chk("disp_bound", 32'((disp >= -8) && (disp <= 8)), 32'd1);
`ifndef TEST_PATTERN_EN
            if (pv == 1 && ph == 0) chk("zero_word0", 32'(tmds_word), 32'(10'b0100000000));
            if (pv == 1 && ph == 1) chk("zero_word1", 32'(tmds_word), 32'(10'b1111111111));
`endif
        end
    endtask

    task automatic run(input int ncyc);
        logic [9:0] tp;
        for (int n = 0; n < ncyc; n++) begin
            check_cycle(n);
            pix_b = (((n / HT) % VT) == 1) ? 8'h00 : 8'($urandom);
`ifdef TEST_PATTERN_EN
            tp      = 10'(n % HT) ^ 10'((n / HT) % VT);
            hist[n] = tp[7:0];
`else
            tp      = '0;
            hist[n] = pix_b + tp[7:0];
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        pix_b = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        // Two full frames, then stop at raster position (25,10).
        run(2 * HT * VT + 10 * HT + 25);
        chk("mid_x", 32'(pix_x), 32'd25);
        chk("mid_y", 32'(pix_y), 32'd10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        disp = 0;
        run(HT * VT + 2 * HT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
